// File: rtl/workload_gen.sv
// Multi-channel workload descriptor source: replays a host-loadable size table,
// serving channels round-robin until each has emitted workload_limit_p descriptors.
module workload_gen #(
    parameter int id_width_p       = 8,
    parameter int size_width_p     = 16,
    parameter int els_p            = 16,
    parameter int channels_p       = 2,
    parameter int workload_limit_p = 16,
    parameter int chan_width_lp    = (channels_p > 1) ? $clog2(channels_p) : 1,
    parameter int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int width_p          = chan_width_lp + id_width_p + size_width_p,
    parameter int count_width_lp   = $clog2(channels_p * workload_limit_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      cfg_v_i,
    input  logic [addr_width_lp-1:0]  cfg_addr_i,
    input  logic [size_width_p-1:0]   cfg_data_i,
    input  logic                      start_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      ready_i,
    output logic                      done_o,
    output logic [count_width_lp-1:0] sent_count_o
);

    // One extra bit so a channel can count all the way up to the limit.
    localparam int wid_width_lp = id_width_p + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                    state_reg, state_next;
    logic [size_width_p-1:0]   rom_reg     [els_p];
    logic [addr_width_lp-1:0]  rd_addr_reg [channels_p];
    logic [addr_width_lp-1:0]  rd_addr_next[channels_p];
    logic [wid_width_lp-1:0]   wid_reg     [channels_p];
    logic [wid_width_lp-1:0]   wid_next    [channels_p];
    logic [chan_width_lp-1:0]  chan_reg, chan_next;
    logic                      v_reg, v_next;
    logic [width_p-1:0]        data_reg, data_next;
    logic [count_width_lp-1:0] count_reg, count_next;
    logic                      accept, restart, cfg_we;
    logic                      found;
    logic [chan_width_lp-1:0]  sel;

    assign accept  = v_reg & ready_i;
    assign restart = start_i & (state_reg != RUN);
    assign cfg_we  = cfg_v_i & (state_reg != RUN);

    genvar gi;
    generate
        for (gi = 0; gi < channels_p; gi++) begin : g_chan
            logic hit;
            assign hit = accept && (chan_reg == chan_width_lp'(gi));
            assign wid_next[gi] = restart ? '0 :
                                  hit ? wid_reg[gi] + wid_width_lp'(1) : wid_reg[gi];
            assign rd_addr_next[gi] = restart ? '0 :
                                      !hit ? rd_addr_reg[gi] :
                                      (rd_addr_reg[gi] == addr_width_lp'(els_p - 1)) ? '0 :
                                      rd_addr_reg[gi] + addr_width_lp'(1);
        end
    endgenerate

    // Next offered channel is searched on post-accept per-channel state, so the
    // accepted channel itself is the last candidate (only chosen if others are done).
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= channels_p; k++) begin
            int idx;
            idx = int'(chan_reg) + k;
            if (idx >= channels_p) idx = idx - channels_p;
            if (!found && (wid_next[idx] < wid_width_lp'(workload_limit_p))) begin
                found = 1'b1;
                sel   = chan_width_lp'(idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        v_next     = v_reg;
        data_next  = data_reg;
        chan_next  = chan_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_i) begin
                    state_next = RUN;
                    v_next     = 1'b1;
                    chan_next  = '0;
                    count_next = '0;
                    data_next  = {chan_width_lp'(0), id_width_p'(0), rom_reg[0]};
                end
            end
            RUN: begin
                if (accept) begin
                    count_next = count_reg + count_width_lp'(1);
                    if (found) begin
                        chan_next = sel;
                        data_next = {sel, wid_next[sel][id_width_p-1:0],
                                     rom_reg[rd_addr_next[sel]]};
                    end else begin
                        v_next     = 1'b0;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            v_reg     <= 1'b0;
            data_reg  <= '0;
            chan_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < channels_p; i++) begin
                rd_addr_reg[i] <= '0;
                wid_reg[i]     <= '0;
            end
        end else begin
            state_reg <= state_next;
            v_reg     <= v_next;
            data_reg  <= data_next;
            chan_reg  <= chan_next;
            count_reg <= count_next;
            for (int i = 0; i < channels_p; i++) begin
                rd_addr_reg[i] <= rd_addr_next[i];
                wid_reg[i]     <= wid_next[i];
            end
        end
    end

    // Table is a reset-to-2 register array; host writes only land outside RUN.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) rom_reg[i] <= size_width_p'(2);
        end else if (cfg_we) begin
            rom_reg[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign v_o          = v_reg;
    assign data_o       = data_reg;
    assign done_o       = (state_reg == DONE);
    assign sent_count_o = count_reg;

endmodule

// File: tb/tb_workload_gen.sv
// Directed bench for workload_gen: a 2-channel/limit-3 instance and a
// 1-channel/limit-4/3-entry instance share clock and reset.
module tb_workload_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: channels 2, limit 3, default 16-entry table
    logic        a_cfg_v, a_start, a_ready, a_v, a_done;
    logic [3:0]  a_cfg_addr;
    logic [15:0] a_cfg_data;
    logic [24:0] a_data;
    logic [2:0]  a_count;

    // Instance B: channels 1, limit 4, 3-entry table
    logic        b_cfg_v, b_start, b_ready, b_v, b_done;
    logic [1:0]  b_cfg_addr;
    logic [15:0] b_cfg_data;
    logic [24:0] b_data;
    logic [2:0]  b_count;

    workload_gen #(.channels_p(2), .workload_limit_p(3)) u_a (
        .clk_i(clk), .reset_n_i(rst_n), .cfg_v_i(a_cfg_v), .cfg_addr_i(a_cfg_addr),
        .cfg_data_i(a_cfg_data), .start_i(a_start), .v_o(a_v), .data_o(a_data),
        .ready_i(a_ready), .done_o(a_done), .sent_count_o(a_count));

    workload_gen #(.channels_p(1), .workload_limit_p(4), .els_p(3)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .cfg_v_i(b_cfg_v), .cfg_addr_i(b_cfg_addr),
        .cfg_data_i(b_cfg_data), .start_i(b_start), .v_o(b_v), .data_o(b_data),
        .ready_i(b_ready), .done_o(b_done), .sent_count_o(b_count));

    int checks_cnt = 0;
    int fail_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] desc(input int c, input int id, input int sz);
        return {1'(c), 8'(id), 16'(sz)};
    endfunction

    // Expected round-robin order for instance A with the default table
    logic [24:0] a_exp [6];

    task automatic check_a_beat(input int i);
        chk($sformatf("a_v[%0d]", i), 64'(a_v), 64'(1));
        chk($sformatf("a_data[%0d]", i), 64'(a_data), 64'(a_exp[i]));
        chk($sformatf("a_count[%0d]", i), 64'(a_count), 64'(i));
    endtask

    task automatic check_a_done(input string tag);
        chk({tag, "_v"}, 64'(a_v), 64'(0));
        chk({tag, "_done"}, 64'(a_done), 64'(1));
        chk({tag, "_count"}, 64'(a_count), 64'(6));
    endtask

    initial begin
        a_exp[0] = desc(0, 0, 2); a_exp[1] = desc(1, 0, 2);
        a_exp[2] = desc(0, 1, 2); a_exp[3] = desc(1, 1, 2);
        a_exp[4] = desc(0, 2, 2); a_exp[5] = desc(1, 2, 2);

        rst_n = 1'b0;
        a_cfg_v = 0; a_start = 0; a_ready = 0; a_cfg_addr = '0; a_cfg_data = '0;
        b_cfg_v = 0; b_start = 0; b_ready = 0; b_cfg_addr = '0; b_cfg_data = '0;
        #2;
        chk("rst_v", 64'(a_v), 64'(0));
        chk("rst_data", 64'(a_data), 64'(0));
        chk("rst_done", 64'(a_done), 64'(0));
        chk("rst_count", 64'(a_count), 64'(0));
        tick(); tick();
        rst_n = 1'b1;

        // Idle for 10 cycles with no start
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_a[%0d]", i), 64'({a_v, a_done, a_count}), 64'(0));
            chk($sformatf("idle_b[%0d]", i), 64'({b_v, b_done, b_count}), 64'(0));
        end

        // Round-robin stream with ready held high
        a_ready = 1; a_start = 1;
        tick();
        a_start = 0;
        for (int i = 0; i < 6; i++) begin
            check_a_beat(i);
            tick();
        end
        check_a_done("rr_end");
        tick(); tick();
        chk("rr_done_hold", 64'(a_done), 64'(1));

        // Restart from DONE, then backpressure plus an ignored start in RUN
        a_start = 1;
        tick();
        a_start = 0;
        chk("restart_done_fall", 64'(a_done), 64'(0));
        check_a_beat(0);
        tick();
        check_a_beat(1);
        a_ready = 0; a_start = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            a_start = 0;
            chk($sformatf("bp_v[%0d]", i), 64'(a_v), 64'(1));
            chk($sformatf("bp_data[%0d]", i), 64'(a_data), 64'(a_exp[1]));
        end
        a_ready = 1;
        for (int i = 1; i < 6; i++) begin
            check_a_beat(i);
            tick();
        end
        check_a_done("bp_end");

        // Instance B: load table 5/6/7 in IDLE, wrap after 3 entries
        for (int i = 0; i < 3; i++) begin
            b_cfg_v = 1; b_cfg_addr = 2'(i); b_cfg_data = 16'(5 + i);
            tick();
        end
        b_cfg_v = 0; b_start = 1; b_ready = 1;
        tick();
        b_start = 0;
        chk("tbl_beat0", 64'(b_data), 64'(desc(0, 0, 5)));
        // Write during RUN must be dropped: entry 0 is reused by beat 3
        b_cfg_v = 1; b_cfg_addr = 2'd0; b_cfg_data = 16'd99;
        tick();
        b_cfg_v = 0;
        chk("tbl_beat1", 64'(b_data), 64'(desc(0, 1, 6)));
        tick();
        chk("tbl_beat2", 64'(b_data), 64'(desc(0, 2, 7)));
        tick();
        chk("tbl_beat3_wrap", 64'(b_data), 64'(desc(0, 3, 5)));
        chk("tbl_beat3_v", 64'(b_v), 64'(1));
        tick();
        chk("tbl_end_v", 64'(b_v), 64'(0));
        chk("tbl_end_done", 64'(b_done), 64'(1));
        chk("tbl_end_count", 64'(b_count), 64'(4));

        // Async reset mid-run after 2 accepted beats
        a_start = 1;
        tick();
        a_start = 0;
        tick(); tick();
        check_a_beat(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_v", 64'(a_v), 64'(0));
        chk("areset_data", 64'(a_data), 64'(0));
        chk("areset_done", 64'(a_done), 64'(0));
        chk("areset_count", 64'(a_count), 64'(0));
        chk("areset_b_done", 64'(b_done), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle_v", 64'(a_v), 64'(0));
        a_start = 1; b_start = 1;
        tick();
        a_start = 0; b_start = 0;
        check_a_beat(0);
        chk("post_rst_b_tbl", 64'(b_data), 64'(desc(0, 0, 2)));
        tick();
        check_a_beat(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/workload_gen.md
# workload_gen

Parametrised multi-channel workload source for the simulation testbench. It replays a shared, host-programmable size table and emits one tagged workload descriptor per handshake on a valid/ready output. Channels are serviced round-robin, each up to a fixed workload limit. It replaces the single-channel, hard-coded-table generator ahead of the accelerator input queue, and adds these behaviours:
- Runtime table load
- Start/restart control
- Per-channel ID streams
- Completion reporting

## Interface
Parameters:
- id_width_p, 8, width of per-channel workload ID
- size_width_p, 16, width of a table entry (workload size)
- els_p, 16, table depth (≥2)
- channels_p, 2, number of channels (≥1)
- workload_limit_p, 16, descriptors per channel per run (1..2^id_width_p)
- chan_width_lp, `BSG_SAFE_CLOG2(channels_p)`, channel tag width
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`, table address width
- width_p, chan_width_lp+id_width_p+size_width_p, descriptor width
- count_width_lp, `BSG_SAFE_CLOG2(channels_p*workload_limit_p+1)`, total-count width

Ports:
- clk_i  in  1  clock; all state on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- cfg_v_i  in  1  table write strobe
- cfg_addr_i  in  addr_width_lp  table write address
- cfg_data_i  in  size_width_p  table write data
- start_i  in  1  start/restart pulse
- v_o  out  1  descriptor valid
- data_o  out  width_p  {chan, workload_id, size}
- ready_i  in  1  consumer ready
- done_o  out  1  run complete
- sent_count_o  out  count_width_lp  descriptors accepted this run

## Operation
- One clock domain. Reset is asynchronous and active-low (reset_n_i). All state is reset on assertion; release is synchronous to clk_i.
- Table: els_p × size_width_p register array. Every entry resets to 2.
  - cfg_v_i writes cfg_data_i to cfg_addr_i in IDLE or DONE.
  - cfg_v_i is ignored in RUN.
- Per-channel state: rd_addr (reset 0), workload_id (reset 0).
- FSM states: IDLE (reset), RUN, DONE.
  - IDLE→RUN when start_i=1.
  - RUN→DONE when the last descriptor of the last unfinished channel is accepted.
  - DONE→RUN when start_i=1. This clears all per-channel state, sent_count_o and the round-robin pointer.
  - start_i in RUN is ignored.
- Arbitration:
  - The round-robin pointer resets to channel 0.
  - After channel c is accepted, the next offered channel is the first channel after c (mod channels_p) with workload_id < workload_limit_p.
  - A finished channel is skipped.
- Output register: holds {chan, workload_id[chan], rom[rd_addr[chan]]}.
  - Accept = v_o & ready_i.
  - On accept, for the accepted channel:
    - workload_id += 1
    - rd_addr += 1, wrapping from els_p-1 to 0 (non-power-of-2 els_p included)
  - On accept, sent_count_o += 1.
- The table entry is sampled at register load. A cfg write cannot alter a held descriptor, since writes are blocked in RUN.

## Timing
- Reset values: v_o=0, data_o=0, done_o=0, sent_count_o=0.
- start_i in IDLE/DONE at cycle t: v_o=1 at t+1 with channel 0 descriptor (id 0, rom[0]).
- Stability: while v_o=1 & ready_i=0, data_o is held stable and v_o stays 1.
- Zero-bubble: accept at cycle t loads the next descriptor for t+1. With ready_i held high this gives 1 descriptor/cycle.
- Final accept at cycle t: at t+1, v_o=0, done_o=1, and sent_count_o=channels_p*workload_limit_p. done_o holds until the next start_i.
- start_i in DONE: done_o=0 and v_o=1 on the next cycle.
- Reset mid-run: outputs go to reset values immediately and asynchronously. Any in-flight descriptor is dropped and the FSM returns to IDLE. The table returns to all 2s.

## Test plan
- Reset/idle: hold reset_n_i=0, then release with no start_i for 10 cycles → v_o=0, done_o=0, sent_count_o=0 throughout.
- Round-robin stream: channels_p=2, workload_limit_p=3, default table, ready_i=1, start_i pulse → 6 consecutive beats:
  - {0,0,2}, {1,0,2}, {0,1,2}, {1,1,2}, {0,2,2}, {1,2,2}
  - then v_o=0, done_o=1, sent_count_o=6
- Backpressure: drop ready_i for 5 cycles mid-stream → data_o unchanged and v_o=1 for all 5 cycles; no skipped or duplicated IDs afterwards.
- Table load and wrap: els_p=3, write entries 5/6/7 in IDLE, channels_p=1, limit 4 → sizes 5,6,7,5. A cfg write during RUN must not change later sizes.
- Restart: start_i in DONE → IDs restart at 0, sizes restart at rom[0], done_o falls in 1 cycle. start_i asserted during RUN has no effect.
- Async reset mid-run: assert reset_n_i between clock edges after 2 beats → v_o=0 before the next edge. After release and start_i, the sequence restarts from {0,0,2}.
